rv_exec_sequencer: RTL and testbench

//  Multi-cycle fetch/decode/execute sequencer for the RV32I core datapath. Drives the instruction
//  on-chip memory (registered address, 1-cycle read latency), the register-file read/write ports
//  and the combinational ALU. Runs a program from RESET_PC on start; reports done/err on ECALL,

---
 rtl/rv_ctrl_pkg.sv | 24 ++
 rtl/rv_imm_gen.sv | 23 ++
 rtl/rv_exec_sequencer.sv | 166 ++++++++++++++++
 tb/tb_rv_exec_sequencer.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared control definitions for the RV32I execute sequencer: state encoding,
// opcode constants, ECALL encoding and branch funct3 codes.
package rv_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [6:0]  OPC_OP     = 7'b0110011;
  localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0]  OPC_LUI    = 7'b0110111;
  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;

  localparam logic [31:0] ECALL_INSN = 32'h0000_0073;

  localparam logic [2:0]  F3_BEQ = 3'b000;
  localparam logic [2:0]  F3_BNE = 3'b001;

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational I/U immediate extraction from the instruction register.
// The B-type immediate output exists only when SEQ_BRANCH_EN is defined.
module rv_imm_gen (
  input  logic [31:0] ir,
  output logic [31:0] imm_i,
  output logic [31:0] imm_u
`ifdef SEQ_BRANCH_EN
  ,
  output logic [31:0] imm_b
`endif
);

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_u = {ir[31:12], 12'h000};

`ifdef SEQ_BRANCH_EN
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
`else
  logic unused_ir_lo;
  assign unused_ir_lo = ^ir[11:0];
`endif

endmodule

// File: rtl/rv_exec_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the RV32I datapath.
// Optional BEQ/BNE support is compiled in with the SEQ_BRANCH_EN macro.
module rv_exec_sequencer
  import rv_ctrl_pkg::*;
#(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  input  logic [31:0]     rf_rs1_data,
  input  logic [31:0]     rf_rs2_data,
  output logic            rf_we,
  output logic [4:0]      rf_rd_addr,
  output logic [31:0]     rf_wd,
  output logic [31:0]     alu_instr,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  input  logic [31:0]     alu_y
);

  localparam logic [PC_W-1:0] PC_RST  = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] PC_LAST = '1;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [31:0]     ir;
  logic [31:0]     result;
  logic [31:0]     imm_i;
  logic [31:0]     imm_u;

`ifdef SEQ_BRANCH_EN
  logic [31:0]     imm_b;

  rv_imm_gen u_imm_gen (
    .ir    (ir),
    .imm_i (imm_i),
    .imm_u (imm_u),
    .imm_b (imm_b)
  );

  logic            br_eq;
  logic            br_taken;
  logic            br_f3_ok;
  logic [PC_W-1:0] br_target;

  // Word-granular PC, so the byte offset is arithmetic-shifted by 2; wrap is allowed.
  assign br_eq     = (rf_rs1_data == rf_rs2_data);
  assign br_taken  = (ir[14:12] == F3_BEQ) ? br_eq : !br_eq;
  assign br_f3_ok  = (ir[14:12] == F3_BEQ) || (ir[14:12] == F3_BNE);
  assign br_target = pc + PC_W'($signed(imm_b) >>> 2);
`else
  rv_imm_gen u_imm_gen (
    .ir    (ir),
    .imm_i (imm_i),
    .imm_u (imm_u)
  );
`endif

  assign imem_addr   = pc;
  assign rf_rs1_addr = ir[19:15];
  assign rf_rs2_addr = ir[24:20];
  assign rf_rd_addr  = ir[11:7];
  assign rf_wd       = result;
  assign alu_instr   = ir;
  assign alu_a       = rf_rs1_data;
  assign alu_b       = (ir[6:0] == OPC_OP) ? rf_rs2_data : imm_i;

  // Sequencer FSM; busy/done/err/rf_we are flops updated alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= PC_RST;
      ir     <= '0;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      rf_we  <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_FETCH;
            pc    <= PC_RST;
            err   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          ir    <= imem_rdata;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (ir[6:0])
            OPC_OP, OPC_OP_IMM: begin
              result <= alu_y;
              rf_we  <= |ir[11:7];
              state  <= S_WB;
            end
            OPC_LUI: begin
              result <= imm_u;
              rf_we  <= |ir[11:7];
              state  <= S_WB;
            end
`ifdef SEQ_BRANCH_EN
            OPC_BRANCH: begin
              if (!br_f3_ok || (imm_b[1:0] != 2'b00)) begin
                state <= S_DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
                err   <= 1'b1;
              end else if (br_taken) begin
                pc    <= br_target;
                state <= S_FETCH;
              end else begin
                state <= S_WB;
              end
            end
`endif
            default: begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              err   <= (ir != ECALL_INSN);
            end
          endcase
        end
        S_WB: begin
          // Last word of instruction memory: the write above still lands, then stop.
          if (pc == PC_LAST) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
          end else begin
            pc    <= pc + PC_W'(1);
            state <= S_FETCH;
          end
        end
        S_DONE: begin
          if (!start) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_exec_sequencer.sv
// Self-checking bench for rv_exec_sequencer: directed vector table, multi-cycle
// corner sequences and random programs checked against an ISA-level model.
module tb_rv_exec_sequencer;

  localparam int unsigned PC_W  = 8;
  localparam int          DEPTH = 256;
  localparam int          LIMIT = 5000;

  logic            clk;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic            err;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [4:0]      rf_rs1_addr;
  logic [4:0]      rf_rs2_addr;
  logic [31:0]     rf_rs1_data;
  logic [31:0]     rf_rs2_data;
  logic            rf_we;
  logic [4:0]      rf_rd_addr;
  logic [31:0]     rf_wd;
  logic [31:0]     alu_instr;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic [31:0]     alu_y;

  rv_exec_sequencer #(.PC_W(PC_W), .RESET_PC(0)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .rf_rs1_addr (rf_rs1_addr),
    .rf_rs2_addr (rf_rs2_addr),
    .rf_rs1_data (rf_rs1_data),
    .rf_rs2_data (rf_rs2_data),
    .rf_we       (rf_we),
    .rf_rd_addr  (rf_rd_addr),
    .rf_wd       (rf_wd),
    .alu_instr   (alu_instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_y       (alu_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  logic [31:0] imem [DEPTH];
  logic [31:0] rf   [32];
  logic [31:0] m_regs [32];
  logic [36:0] got_q [$];
  logic [36:0] exp_q [$];
  logic        m_err;
  int          m_cyc;
  int          double_cnt = 0;
  logic        prev_we = 1'b0;
  logic [31:0] cap_a = '0;
  logic [31:0] cap_b = '0;

  function automatic logic [31:0] alu_f(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    case (ins[14:12])
      3'b000:  return (ins[6:0] == 7'b0110011 && ins[30]) ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b100:  return a ^ b;
      3'b110:  return a | b;
      3'b111:  return a & b;
      default: return a + b;
    endcase
  endfunction

  // Environment: 1-cycle-latency instruction memory, regfile, ALU
  always @(posedge clk) imem_rdata <= imem[imem_addr];
  assign rf_rs1_data = (rf_rs1_addr == 5'd0) ? 32'd0 : rf[rf_rs1_addr];
  assign rf_rs2_data = (rf_rs2_addr == 5'd0) ? 32'd0 : rf[rf_rs2_addr];
  assign alu_y = alu_f(alu_instr, alu_a, alu_b);

  always @(posedge clk) begin
    if (rf_we) begin
      if (rf_rd_addr != 5'd0) rf[rf_rd_addr] <= rf_wd;
      got_q.push_back({rf_rd_addr, rf_wd});
      if (rf_rd_addr == 5'd6) begin
        cap_a <= alu_a;
        cap_b <= alu_b;
      end
      if (prev_we) double_cnt++;
    end
    prev_we <= rf_we;
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [4:0] rd);
    return {imm, rs1, 3'b000, rd, 7'b0010011};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd);
    return {imm, rd, 7'b0110111};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] off);
    return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act === expv) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic kick();
    @(negedge clk) start = 1'b1;
    step(1);
    @(negedge clk) start = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < DEPTH; i++) imem[i] = 32'h0;
  endtask

  // Runs from start to done; cycles counted from the edge that accepts start.
  task automatic run_prog(input bit hold, output logic e, output int c);
    @(negedge clk) start = 1'b1;
    step(1);
    @(negedge clk) start = hold;
    c = 0;
    while (done !== 1'b1 && c < LIMIT) begin
      step(1);
      c++;
    end
    if (c >= LIMIT) chk("run_timeout", 32'(done), 32'd1);
    e = err;
    if (!hold) step(1);
  endtask

  // ISA-level reference: walks the program word by word, 4 cycles per retired
  // instruction, 3 for ones that stop in execute or branch away.
  task automatic run_model();
    int pc;
    int off;
    bit fin;
    logic [31:0] w, a, b, y;
    exp_q.delete();
    m_err = 1'b0;
    m_cyc = 0;
    pc = 0;
    fin = 1'b0;
    for (int s = 0; s < 100000 && !fin; s++) begin
      w = imem[pc];
      a = m_regs[w[19:15]];
      b = m_regs[w[24:20]];
      case (w[6:0])
        7'b0110011, 7'b0010011, 7'b0110111: begin
          if (w[6:0] == 7'b0110111) y = {w[31:12], 12'h000};
          else y = alu_f(w, a, (w[6:0] == 7'b0110011) ? b : {{20{w[31]}}, w[31:20]});
          if (w[11:7] != 5'd0) begin
            m_regs[w[11:7]] = y;
            exp_q.push_back({w[11:7], y});
          end
          m_cyc += 4;
          if (pc == DEPTH - 1) begin m_err = 1'b1; fin = 1'b1; end
          else pc++;
        end
        7'b1100011: begin
`ifdef SEQ_BRANCH_EN
          off = int'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
          if (w[14:12] > 3'd1 || (off % 4) != 0) begin
            m_cyc += 3; m_err = 1'b1; fin = 1'b1;
          end else if ((w[14:12] == 3'd0) == (a == b)) begin
            m_cyc += 3;
            pc = (((pc + off / 4) % DEPTH) + DEPTH) % DEPTH;
          end else begin
            m_cyc += 4;
            if (pc == DEPTH - 1) begin m_err = 1'b1; fin = 1'b1; end
            else pc++;
          end
`else
          off = 0;
          m_cyc += 3 + off; m_err = 1'b1; fin = 1'b1;
`endif
        end
        default: begin
          m_cyc += 3;
          m_err = (w != 32'h0000_0073);
          fin = 1'b1;
        end
      endcase
    end
  endtask

  task automatic compare_run(input string name);
    logic e;
    int c;
    m_regs = rf;
    m_regs[0] = 32'h0;
    run_model();
    got_q.delete();
    double_cnt = 0;
    run_prog(1'b0, e, c);
    chk($sformatf("%s.err", name), 32'(e), 32'(m_err));
    chk($sformatf("%s.cycles", name), 32'(c), 32'(m_cyc));
    chk($sformatf("%s.nwrites", name), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s.write%0d", name, i), 32'(got_q[i][36:32] ^ got_q[i][31:0] ^ (got_q[i] >> 5)),
          32'(exp_q[i][36:32] ^ exp_q[i][31:0] ^ (exp_q[i] >> 5)));
    chk($sformatf("%s.we_pulse", name), 32'(double_cnt), 32'd0);
  endtask

  typedef struct {
    logic [3:0][31:0] prog;
    int               len;
    logic             err;
    int               cyc;
    int               nw;
    logic [4:0]       rd;
    logic [31:0]      wd;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic e;
    int c;
    logic [2:0] f3s [5];
    int n;
    logic [31:0] w;

    f3s = '{3'd0, 3'd1, 3'd4, 3'd6, 3'd7};
    rst = 1'b1;
    start = 1'b0;
    clear_imem();
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;

    vt[0].prog[0] = enc_i(12'd7, 5'd0, 5'd5);   vt[0].prog[1] = 32'h73;
    vt[0].len = 2; vt[0].err = 1'b0; vt[0].cyc = 7;  vt[0].nw = 1; vt[0].rd = 5'd5; vt[0].wd = 32'd7;
    vt[1].prog[0] = enc_i(12'd7, 5'd0, 5'd5);   vt[1].prog[1] = enc_r(7'd0, 5'd5, 5'd5, 3'd0, 5'd6);
    vt[1].prog[2] = 32'h73;
    vt[1].len = 3; vt[1].err = 1'b0; vt[1].cyc = 11; vt[1].nw = 2; vt[1].rd = 5'd6; vt[1].wd = 32'd14;
    vt[2].prog[0] = enc_i(12'd5, 5'd0, 5'd0);   vt[2].prog[1] = enc_u(20'hABCDE, 5'd7);
    vt[2].prog[2] = 32'h73;
    vt[2].len = 3; vt[2].err = 1'b0; vt[2].cyc = 11; vt[2].nw = 1; vt[2].rd = 5'd7; vt[2].wd = 32'hABCDE000;
    vt[3].prog[0] = 32'hFFFF_FFFF;
    vt[3].len = 1; vt[3].err = 1'b1; vt[3].cyc = 3;  vt[3].nw = 0; vt[3].rd = 5'd0; vt[3].wd = 32'd0;
    vt[4].prog[0] = enc_i(12'hFFD, 5'd0, 5'd3); vt[4].prog[1] = enc_r(7'h20, 5'd3, 5'd0, 3'd0, 5'd4);
    vt[4].prog[2] = 32'h0010_0073;
    vt[4].len = 3; vt[4].err = 1'b1; vt[4].cyc = 11; vt[4].nw = 2; vt[4].rd = 5'd4; vt[4].wd = 32'd3;

    step(3);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.err", 32'(err), 32'd0);
    chk("rst.rf_we", 32'(rf_we), 32'd0);
    chk("rst.imem_addr", 32'(imem_addr), 32'd0);
    chk("rst.rf_wd", rf_wd, 32'd0);
    chk("rst.ir", alu_instr, 32'd0);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 5; i++) begin
      clear_imem();
      for (int j = 0; j < vt[i].len; j++) imem[j] = vt[i].prog[j];
      got_q.delete();
      double_cnt = 0;
      run_prog(1'b0, e, c);
      chk($sformatf("vec%0d.err", i), 32'(e), 32'(vt[i].err));
      chk($sformatf("vec%0d.cycles", i), 32'(c), 32'(vt[i].cyc));
      chk($sformatf("vec%0d.nwrites", i), 32'(got_q.size()), 32'(vt[i].nw));
      chk($sformatf("vec%0d.we_pulse", i), 32'(double_cnt), 32'd0);
      if (vt[i].nw > 0 && got_q.size() > 0) begin
        chk($sformatf("vec%0d.rd", i), 32'(got_q[$][36:32]), 32'(vt[i].rd));
        chk($sformatf("vec%0d.wd", i), got_q[$][31:0], vt[i].wd);
      end
    end
    chk("add.alu_a", cap_a, 32'd7);
    chk("add.alu_b", cap_b, 32'd7);

    // Illegal word with start held high: done must persist until start drops
    clear_imem();
    imem[0] = 32'hFFFF_FFFF;
    got_q.delete();
    run_prog(1'b1, e, c);
    chk("hold.err", 32'(e), 32'd1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (done === 1'b1 && err === 1'b1) n++;
    end
    chk("hold.done_cycles", 32'(n), 32'd5);
    chk("hold.nwrites", 32'(got_q.size()), 32'd0);
    @(negedge clk) start = 1'b0;
    step(1);
    chk("hold.release_done", 32'(done), 32'd0);
    chk("hold.release_busy", 32'(busy), 32'd0);

    // Reset during EXEC, then during WB, of the second instruction
    for (int k = 6; k <= 7; k++) begin
      clear_imem();
      imem[0] = enc_i(12'd7, 5'd0, 5'd5);
      imem[1] = enc_i(12'd9, 5'd0, 5'd6);
      imem[2] = 32'h73;
      got_q.delete();
      kick();
      step(k);
      chk($sformatf("abort%0d.pc", k), 32'(imem_addr), 32'd1);
      chk($sformatf("abort%0d.we_before", k), 32'(rf_we), 32'(k == 7));
      rst = 1'b1;
      #1;
      chk($sformatf("abort%0d.we", k), 32'(rf_we), 32'd0);
      chk($sformatf("abort%0d.busy", k), 32'(busy), 32'd0);
      chk($sformatf("abort%0d.pc_rst", k), 32'(imem_addr), 32'd0);
      @(negedge clk) rst = 1'b0;
      step(1);
      chk($sformatf("abort%0d.nwrites", k), 32'(got_q.size()), 32'd1);
      compare_run($sformatf("rerun%0d", k));
    end

    // Last word of memory: write still happens, then overflow error
    for (int i = 0; i < DEPTH; i++) imem[i] = enc_i(12'd1, 5'd1, 5'd1);
    compare_run("pc_overflow");

    // Branch-encoded programs: taken forward, misaligned, unsupported funct3
    clear_imem();
    imem[0] = enc_b(3'd0, 5'd0, 5'd0, 13'd8);
    imem[2] = 32'h73;
    compare_run("br_fwd");
    clear_imem();
    imem[0] = enc_b(3'd0, 5'd0, 5'd0, 13'd2);
    compare_run("br_misalign");
    clear_imem();
    imem[0] = enc_b(3'd4, 5'd0, 5'd0, 13'd8);
    compare_run("br_f3");

`ifdef SEQ_BRANCH_EN
    // beq/bne x1,x2,-8 at PC 3 with x1==x2
    for (int k = 0; k < 2; k++) begin
      clear_imem();
      for (int i = 0; i < 3; i++) imem[i] = enc_i(12'd0, 5'd0, 5'd0);
      imem[3] = enc_b(3'(k), 5'd1, 5'd2, 13'h1FF8);
      rf[1] = 32'd5;
      rf[2] = 32'd5;
      kick();
      step(15 + k);
      chk($sformatf("branch%0d.next_pc", k), 32'(imem_addr), (k == 0) ? 32'd1 : 32'd4);
      pulse_reset();
    end
    for (int i = 0; i < DEPTH - 1; i++) imem[i] = enc_i(12'd0, 5'd0, 5'd0);
    imem[DEPTH-1] = enc_b(3'd1, 5'd0, 5'd0, 13'd8);
    compare_run("br_last_pc");
`endif

    // Random straight-line programs against the reference model
    for (int t = 0; t < 25; t++) begin
      clear_imem();
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 8))
          0, 1, 2, 3: w = enc_i(12'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
          4, 5, 6:    w = enc_r(($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00, 5'($urandom_range(0, 7)),
                                5'($urandom_range(0, 7)), f3s[$urandom_range(0, 4)], 5'($urandom_range(0, 7)));
          7:          w = enc_u(20'($urandom), 5'($urandom_range(0, 7)));
          default:    w = enc_i(12'($urandom), 5'($urandom_range(0, 7)), 5'd0);
        endcase
        imem[i] = w;
      end
      imem[n] = ($urandom_range(0, 2) == 0) ? 32'h0000_0003 : 32'h0000_0073;
      compare_run($sformatf("rand%0d", t));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
